// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, fills IF/ID, redirects on EX-resolved branches (optional BRANCH_DELAY_SLOT_EN).
// Latency: IF/ID loads on each falling edge; a taken branch reaches IF/ID 2 edges after the redirect edge.
// Backpressure: if_stall holds the PC, IF/ID and fetch_count; a redirect overrides a stall.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        ex_npc_sel,
  input  logic [31:0] ex_pc4,
  input  logic [15:0] ex_imm16,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        flush_id,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = ex_pc4 + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        inst_d  = NOP_INST;
        pc4_d   = 32'd0;
        vld_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (ex_npc_sel) begin
          pc_d    = br_target;
          inst_d  = NOP_INST;
          pc4_d   = 32'd0;
          vld_d   = 1'b0;
          state_d = REDIR;
        end else if (!if_stall) begin
          pc_d   = pc_plus4;
          inst_d = imem_data;
          pc4_d  = pc_plus4;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + 32'd1;
        end
      end
      REDIR: begin
        // Target is settling on imem_addr; any branch seen here is a squashed bubble.
        inst_d  = NOP_INST;
        pc4_d   = 32'd0;
        vld_d   = 1'b0;
        state_d = RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      vld_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[31:2], 2'b00};
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = vld_q;
  assign fetch_count = cnt_q;

`ifdef BRANCH_DELAY_SLOT_EN
  // The instruction in ID is the delay slot and must execute.
  assign flush_id = 1'b0;
`else
  assign flush_id = ex_npc_sel & (state_q == RUN);
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, fetch order, stall, redirect, wrap and reset-in-redirect.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        ex_npc_sel;
  logic [31:0] ex_pc4;
  logic [15:0] ex_imm16;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        flush_id;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_stall   (if_stall),
    .ex_npc_sel (ex_npc_sel),
    .ex_pc4     (ex_pc4),
    .ex_imm16   (ex_imm16),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_id_inst (if_id_inst),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .flush_id   (flush_id),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Instruction memory: distinct, recognisable word per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_data = word_at(imem_addr);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic EXP_FLUSH = 1'b0;
`else
  localparam logic EXP_FLUSH = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    check({tag, "_pc"},    imem_addr, exp_pc);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_inst"},  if_id_inst, 32'h0000_0000);
    check({tag, "_cnt"},   fetch_count, exp_cnt);
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] fetched_pc, input logic [31:0] exp_cnt);
    check({tag, "_inst"},  if_id_inst, word_at(fetched_pc));
    check({tag, "_pc4"},   if_id_pc4, fetched_pc + 32'd4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
    check({tag, "_cnt"},   fetch_count, exp_cnt);
    check({tag, "_pc"},    imem_addr, fetched_pc + 32'd4);
  endtask

  initial begin
    rst        = 1'b1;
    if_stall   = 1'b0;
    ex_npc_sel = 1'b0;
    ex_pc4     = 32'd0;
    ex_imm16   = 16'd0;

    // Reset and boot
    #2;
    step();
    check_bubble("reset", 32'h0, 32'd0);
    check("reset_pc4", if_id_pc4, 32'd0);
    rst = 1'b0;
    step();
    check_bubble("boot", 32'h0, 32'd0);
    step();
    check_fetch("fetchA", 32'h0, 32'd1);
    step();
    check_fetch("fetchB", 32'h4, 32'd2);

    // Stall three edges at pc=8
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch("stall", 32'h4, 32'd2);
    end
    if_stall = 1'b0;
    step();
    check_fetch("fetchC", 32'h8, 32'd3);
    step();
    check_fetch("fetchD", 32'hC, 32'd4);

    // Taken branch back to 0x0C
    ex_npc_sel = 1'b1;
    ex_pc4     = 32'h10;
    ex_imm16   = 16'hFFFF;
    #1;
    check("flush_run", {31'd0, flush_id}, {31'd0, EXP_FLUSH});
    step();
    check_bubble("redir1", 32'hC, 32'd4);
    // A branch seen in REDIR is ignored
    ex_pc4 = 32'h100;
    #1;
    check("flush_redir", {31'd0, flush_id}, 32'd0);
    step();
    check_bubble("redir2", 32'hC, 32'd4);
    ex_npc_sel = 1'b0;
    #1;
    check("flush_idle", {31'd0, flush_id}, 32'd0);
    step();
    check_fetch("target", 32'hC, 32'd5);

    // Redirect beats simultaneous stall; target 0x3C+4=0x40
    ex_npc_sel = 1'b1;
    if_stall   = 1'b1;
    ex_pc4     = 32'h3C;
    ex_imm16   = 16'h0001;
    step();
    check_bubble("redir_stall", 32'h40, 32'd5);
    ex_npc_sel = 1'b0;
    if_stall   = 1'b0;
    step();
    check_bubble("redir_stall2", 32'h40, 32'd5);
    step();
    check_fetch("fetch40", 32'h40, 32'd6);

    // Branch to 0xFFFF_FFFC then wrap to 0
    ex_npc_sel = 1'b1;
    ex_pc4     = 32'h0;
    ex_imm16   = 16'hFFFF;
    step();
    check_bubble("to_top", 32'hFFFF_FFFC, 32'd6);
    ex_npc_sel = 1'b0;
    step();
    step();
    check("wrap_inst", if_id_inst, word_at(32'hFFFF_FFFC));
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_cnt", fetch_count, 32'd7);

    // Unaligned sum is forced to a word boundary: 0x13+4=0x17 -> 0x14
    ex_npc_sel = 1'b1;
    ex_pc4     = 32'h13;
    ex_imm16   = 16'h0001;
    step();
    check_bubble("align", 32'h14, 32'd7);
    ex_npc_sel = 1'b0;

    // Reset while in REDIR
    rst = 1'b1;
    step();
    check_bubble("rst_redir", 32'h0, 32'd0);
    rst = 1'b0;
    step();
    check_bubble("rst_boot", 32'h0, 32'd0);
    step();
    check_fetch("rst_fetch", 32'h0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
